mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port unified instruction/data memory of the SCP core between the
//  fetch unit (IFU) and the load/store unit (LSU). Grants one request at a time, keeps
//  one transaction outstanding and routes the response back to its owner. Data accesses
//  have priority; a starvation counter guarantees fetch progress. Sits between core and memory.
// PARAMETERS
//  AW          32  address width (byte address)
//  DW          32  data width
//  STARVE_MAX  4   consecutive lost IFU arbitration cycles before IFU gets priority (>=1)
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rst         in   1      asynchronous, active-high reset
//  ifu_req     in   1      fetch request; held high with ifu_addr stable until ifu_gnt
//  ifu_addr    in   AW     fetch address
//  ifu_gnt     out  1      fetch request accepted this cycle
//  ifu_rvalid  out  1      fetch data valid on rdata (1-cycle pulse)
//  lsu_req     in   1      load/store request; held with its fields stable until lsu_gnt
//  lsu_we      in   1      1 = store, 0 = load
//  lsu_addr    in   AW     data address
//  lsu_wdata   in   DW     store data
//  lsu_be      in   DW/8   byte enables
//  lsu_gnt     out  1      data request accepted this cycle
//  lsu_rvalid  out  1      load data / store ack valid (1-cycle pulse)
//  rdata       out  DW     = mem_rdata, broadcast to both requesters, qualified by *_rvalid
//  mem_req     out  1      memory request
//  mem_we      out  1      memory write enable
//  mem_addr    out  AW     memory address
//  mem_wdata   out  DW     memory write data
//  mem_be      out  DW/8   memory byte enables (all ones for fetch)
//  mem_gnt     in   1      memory accepts request this cycle
//  mem_rvalid  in   1      memory response valid (reads and writes both respond)
//  mem_rdata   in   DW     memory read data
//  err         out  1      sticky: mem_rvalid seen while nothing outstanding
// BEHAVIOUR
//  - Reset: state IDLE, owner NONE, starve_cnt 0, err 0; all *_gnt, *_rvalid, mem_req 0.
//  - FSM IDLE: sel = IFU if (ifu_req & (!lsu_req | starve_cnt==STARVE_MAX)) else LSU.
//    mem_req = ifu_req|lsu_req; mem_* fields muxed combinationally from sel (zero latency);
//    IFU request drives mem_we=0, mem_wdata=0, mem_be=all ones.
//    sel_gnt = mem_gnt & mem_req (combinational); on it owner<=sel, go WAIT_RSP.
//  - FSM WAIT_RSP: mem_req=0, both gnt=0; on mem_rvalid assert owner's rvalid same cycle
//    (combinational), owner<=NONE, go IDLE. No new issue in the response cycle:
//    peak throughput one transaction per 2 cycles.
//  - starve_cnt: in IDLE, +1 (saturating at STARVE_MAX) each cycle ifu_req=1 and IFU not
//    granted; cleared when ifu_gnt=1; holds in WAIT_RSP; cleared if ifu_req drops.
//  - mem_gnt=0 in IDLE: stay IDLE, re-arbitrate next cycle (sel may change if IFU hits
//    STARVE_MAX; an un-granted request may be overtaken).
//  - mem_rvalid in IDLE: ignored (no rvalid out), err<=1 until reset.
//  - Simultaneous mem_rvalid and new requests: requests wait one cycle (IDLE next cycle).
//  - Reset mid-transaction: back to IDLE/NONE; in-flight response not delivered.
// STRUCTURE
//  - Shared package scp_pkg: typedef arb_state_t {IDLE, WAIT_RSP}; arb_owner_t {NONE,IFU,LSU}.
//  - One sub-module natural: arb_starve_ctr (saturating counter, inc/clr, at_max output).
//  - Remainder: 2-state FSM + combinational request mux/response demux in this file.
// TESTING
//  1 Reset: rst=1 with reqs high -> all gnt/rvalid/mem_req 0, err 0; release -> arbitration.
//  2 IFU only, addr 0x10, mem_gnt=1, rvalid 1 cycle later rdata 0x00500093 -> ifu_gnt cyc0,
//    ifu_rvalid cyc1 with rdata 0x00500093, lsu_rvalid 0 throughout.
//  3 Both req, lsu store addr 0x200 wdata 0xDEADBEEF be 0xF -> LSU granted first, mem_we=1;
//    IFU granted on next IDLE cycle, mem_we=0, mem_be=0xF.
//  4 LSU req held continuously, IFU req held, STARVE_MAX=4 -> IFU granted on its 5th
//    IDLE arbitration cycle, counter cleared, LSU granted next IDLE.
//  5 mem_gnt=0 for 3 cycles with IFU req -> mem_req high, fields stable, no gnt; then grant.
//  6 mem_rvalid pulsed in IDLE -> no rvalid out, err=1 sticky until rst; rst mid WAIT_RSP
//    -> late mem_rvalid produces no *_rvalid.

Source files
------------

// File: rtl/scp_pkg.sv
// Shared types for the SCP core memory-port arbiter: FSM states, transaction
// owners and the arbitration decision used by the request mux.
package scp_pkg;

  typedef enum logic {
    IDLE,
    WAIT_RSP
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    IFU,
    LSU
  } arb_owner_t;

  // Data accesses normally win; a fetch that has lost too often takes the port
  function automatic logic ifu_wins(input logic ifuReq, input logic lsuReq,
                                    input logic starveAtMax);
    return ifuReq & (~lsuReq | starveAtMax);
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter: counts lost fetch arbitration cycles and
// flags when the fetch unit has waited long enough to be given priority.
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign at_max_o = (cnt_q == CW'(MAX));

  // Clear wins over increment; increment stops once the limit is reached
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port instruction/data memory between the fetch unit and
// the load/store unit. One transaction outstanding at a time; the response is
// steered back to whichever side issued it.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_gnt,
  output logic            ifu_rvalid,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_be,
  output logic            lsu_gnt,
  output logic            lsu_rvalid,
  output logic [DW-1:0]   rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            err
);

  import scp_pkg::*;

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  logic       err_q, err_d;

  logic selIfu;
  logic issueGnt;
  logic starveAtMax;
  logic starveInc;
  logic starveClr;

  // Read data is broadcast; the per-requester rvalid decides who takes it
  assign rdata = mem_rdata;
  assign err   = err_q;

  // Fetch loses a cycle whenever it asks in IDLE and is not the one granted
  assign starveInc = (state_q == IDLE) & ifu_req & ~ifu_gnt;
  assign starveClr = ifu_gnt | ~ifu_req;

  arb_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (starveInc),
    .clr_i   (starveClr),
    .at_max_o(starveAtMax)
  );

  // Request mux toward memory and response demux back to the owner
  always_comb begin
    selIfu     = ifu_wins(ifu_req, lsu_req, starveAtMax);
    issueGnt   = 1'b0;
    ifu_gnt    = 1'b0;
    lsu_gnt    = 1'b0;
    ifu_rvalid = 1'b0;
    lsu_rvalid = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          mem_req = ifu_req | lsu_req;
          if (selIfu) begin
            mem_we    = 1'b0;
            mem_addr  = ifu_addr;
            mem_wdata = '0;
            mem_be    = '1;
          end else begin
            mem_we    = lsu_we;
            mem_addr  = lsu_addr;
            mem_wdata = lsu_wdata;
            mem_be    = lsu_be;
          end
          issueGnt = mem_gnt & mem_req;
          ifu_gnt  = issueGnt & selIfu;
          lsu_gnt  = issueGnt & ~selIfu;
        end
        WAIT_RSP: begin
          ifu_rvalid = mem_rvalid & (owner_q == IFU);
          lsu_rvalid = mem_rvalid & (owner_q == LSU);
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

  // Next-state: issue moves to WAIT_RSP, any response returns to IDLE
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (issueGnt) begin
          state_d = WAIT_RSP;
          owner_d = selIfu ? IFU : LSU;
        end
        if (mem_rvalid) begin
          err_d = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          owner_d = NONE;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = NONE;
      end
    endcase
  end

  // FSM state, transaction owner and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= NONE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for starvation and reset during a transaction.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_gnt;
  logic        ifu_rvalid;
  logic        lsu_req;
  logic        lsu_we;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_be;
  logic        lsu_gnt;
  logic        lsu_rvalid;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic        ifuReq;
    logic [31:0] ifuAddr;
    logic        lsuReq;
    logic        lsuWe;
    logic [31:0] lsuAddr;
    logic [31:0] lsuWdata;
    logic [3:0]  lsuBe;
    logic        memGnt;
    logic        memRvalid;
    logic [31:0] memRdata;
    logic        expIfuGnt;
    logic        expIfuRvalid;
    logic        expLsuGnt;
    logic        expLsuRvalid;
    logic        expMemReq;
    logic        expMemWe;
    logic [31:0] expMemAddr;
    logic [31:0] expMemWdata;
    logic [3:0]  expMemBe;
    logic        expErr;
  } vecT;

  vecT vecs[$];

  mem_port_arbiter #(
    .AW(32),
    .DW(32),
    .STARVE_MAX(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ifu_req   (ifu_req),
    .ifu_addr  (ifu_addr),
    .ifu_gnt   (ifu_gnt),
    .ifu_rvalid(ifu_rvalid),
    .lsu_req   (lsu_req),
    .lsu_we    (lsu_we),
    .lsu_addr  (lsu_addr),
    .lsu_wdata (lsu_wdata),
    .lsu_be    (lsu_be),
    .lsu_gnt   (lsu_gnt),
    .lsu_rvalid(lsu_rvalid),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic addVec(input string n, input logic r,
                        input logic iReq, input logic [31:0] iAddr,
                        input logic lReq, input logic lWe, input logic [31:0] lAddr,
                        input logic [31:0] lWdata, input logic [3:0] lBe,
                        input logic mGnt, input logic mRv, input logic [31:0] mRdata,
                        input logic eIG, input logic eIR, input logic eLG, input logic eLR,
                        input logic eReq, input logic eWe, input logic [31:0] eAddr,
                        input logic [31:0] eWdata, input logic [3:0] eBe, input logic eErr);
    vecT v;
    v.name = n; v.rst = r;
    v.ifuReq = iReq; v.ifuAddr = iAddr;
    v.lsuReq = lReq; v.lsuWe = lWe; v.lsuAddr = lAddr; v.lsuWdata = lWdata; v.lsuBe = lBe;
    v.memGnt = mGnt; v.memRvalid = mRv; v.memRdata = mRdata;
    v.expIfuGnt = eIG; v.expIfuRvalid = eIR; v.expLsuGnt = eLG; v.expLsuRvalid = eLR;
    v.expMemReq = eReq; v.expMemWe = eWe; v.expMemAddr = eAddr;
    v.expMemWdata = eWdata; v.expMemBe = eBe; v.expErr = eErr;
    vecs.push_back(v);
  endtask

  task automatic driveIdle();
    ifu_req    = 1'b0;
    ifu_addr   = '0;
    lsu_req    = 1'b0;
    lsu_we     = 1'b0;
    lsu_addr   = '0;
    lsu_wdata  = '0;
    lsu_be     = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic applyStimulus(input vecT v);
    rst        = v.rst;
    ifu_req    = v.ifuReq;
    ifu_addr   = v.ifuAddr;
    lsu_req    = v.lsuReq;
    lsu_we     = v.lsuWe;
    lsu_addr   = v.lsuAddr;
    lsu_wdata  = v.lsuWdata;
    lsu_be     = v.lsuBe;
    mem_gnt    = v.memGnt;
    mem_rvalid = v.memRvalid;
    mem_rdata  = v.memRdata;
  endtask

  task automatic checkOutput(input vecT v);
    checkVal({v.name, ".ifu_gnt"},    ifu_gnt,    v.expIfuGnt);
    checkVal({v.name, ".lsu_gnt"},    lsu_gnt,    v.expLsuGnt);
    checkVal({v.name, ".ifu_rvalid"}, ifu_rvalid, v.expIfuRvalid);
    checkVal({v.name, ".lsu_rvalid"}, lsu_rvalid, v.expLsuRvalid);
    checkVal({v.name, ".mem_req"},    mem_req,    v.expMemReq);
    checkVal({v.name, ".err"},        err,        v.expErr);
    if (v.expMemReq) begin
      checkVal({v.name, ".mem_we"},    mem_we,    v.expMemWe);
      checkVal({v.name, ".mem_addr"},  mem_addr,  v.expMemAddr);
      checkVal({v.name, ".mem_wdata"}, mem_wdata, v.expMemWdata);
      checkVal({v.name, ".mem_be"},    mem_be,    v.expMemBe);
    end
    if (v.expIfuRvalid || v.expLsuRvalid) begin
      checkVal({v.name, ".rdata"}, rdata, v.memRdata);
    end
  endtask

  logic expIfu;

  initial begin
    rst = 1'b1;
    driveIdle();

    //      name              rst iReq iAddr         lReq lWe lAddr         lWdata        lBe    mGnt mRv mRdata        iG iR lG lR req we addr          wdata         be     err
    addVec("rst_hold",        1, 1, 32'h0000_0010, 1, 1, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF, 1, 0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         4'h0, 0);
    addVec("rst_hold_rv",     1, 1, 32'h0000_0010, 1, 1, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF, 1, 1, 32'h1,         0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         4'h0, 0);
    addVec("ifu_only_issue",  0, 1, 32'h0000_0010, 0, 0, 32'h0,         32'h0,         4'h0, 1, 0, 32'h0,         1, 0, 0, 0, 1, 0, 32'h0000_0010, 32'h0,         4'hF, 0);
    addVec("ifu_only_rsp",    0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 1, 1, 32'h0050_0093, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0,         4'h0, 0);
    addVec("idle_quiet",      0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         4'h0, 0);
    addVec("both_lsu_first",  0, 1, 32'h0000_0014, 1, 1, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF, 1, 0, 32'h0,         0, 0, 1, 0, 1, 1, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF, 0);
    addVec("lsu_store_ack",   0, 1, 32'h0000_0014, 0, 0, 32'h0,         32'h0,         4'h0, 1, 1, 32'h0,         0, 0, 0, 1, 0, 0, 32'h0,         32'h0,         4'h0, 0);
    addVec("ifu_after_lsu",   0, 1, 32'h0000_0014, 0, 0, 32'h0,         32'h0,         4'h0, 1, 0, 32'h0,         1, 0, 0, 0, 1, 0, 32'h0000_0014, 32'h0,         4'hF, 0);
    addVec("ifu_rsp2",        0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 0, 1, 32'h1234_5678, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0,         4'h0, 0);
    addVec("stall_1",         0, 1, 32'h0000_0040, 0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 32'h0,         0, 0, 0, 0, 1, 0, 32'h0000_0040, 32'h0,         4'hF, 0);
    addVec("stall_2",         0, 1, 32'h0000_0040, 0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 32'h0,         0, 0, 0, 0, 1, 0, 32'h0000_0040, 32'h0,         4'hF, 0);
    addVec("stall_3",         0, 1, 32'h0000_0040, 0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 32'h0,         0, 0, 0, 0, 1, 0, 32'h0000_0040, 32'h0,         4'hF, 0);
    addVec("stall_grant",     0, 1, 32'h0000_0040, 0, 0, 32'h0,         32'h0,         4'h0, 1, 0, 32'h0,         1, 0, 0, 0, 1, 0, 32'h0000_0040, 32'h0,         4'hF, 0);
    addVec("stall_rsp",       0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 0, 1, 32'hCAFE_F00D, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0,         4'h0, 0);
    addVec("stray_rvalid",    0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 0, 1, 32'hAAAA_5555, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         4'h0, 0);
    addVec("err_sticky",      0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         4'h0, 1);
    addVec("lsu_load_issue",  0, 0, 32'h0,         1, 0, 32'h0000_0300, 32'h0000_0011, 4'h3, 1, 0, 32'h0,         0, 0, 1, 0, 1, 0, 32'h0000_0300, 32'h0000_0011, 4'h3, 1);
    addVec("lsu_load_rsp",    0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 0, 1, 32'h0000_0055, 0, 0, 0, 1, 0, 0, 32'h0,         32'h0,         4'h0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i]);
      @(posedge clk);
      #1;
    end

    // Starvation: both sides hold requests; fetch wins its 5th arbitration
    driveIdle();
    ifu_req  = 1'b1;
    ifu_addr = 32'h0000_0080;
    lsu_req  = 1'b1;
    lsu_we   = 1'b0;
    lsu_addr = 32'h0000_0400;
    lsu_be   = 4'hF;
    mem_gnt  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      mem_rvalid = 1'b0;
      @(negedge clk);
      expIfu = (k == 5);
      checkVal($sformatf("starve_k%0d.ifu_gnt", k), ifu_gnt, expIfu);
      checkVal($sformatf("starve_k%0d.lsu_gnt", k), lsu_gnt, !expIfu);
      checkVal($sformatf("starve_k%0d.mem_addr", k), mem_addr, expIfu ? 32'h80 : 32'h400);
      @(posedge clk);
      #1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1000 + k;
      @(negedge clk);
      checkVal($sformatf("starve_k%0d.ifu_rvalid", k), ifu_rvalid, expIfu);
      checkVal($sformatf("starve_k%0d.lsu_rvalid", k), lsu_rvalid, !expIfu);
      checkVal($sformatf("starve_k%0d.rdata", k), rdata, 32'h1000 + k);
      @(posedge clk);
      #1;
    end

    // Reset while a load is outstanding; the late response must be dropped
    driveIdle();
    lsu_req  = 1'b1;
    lsu_addr = 32'h0000_0500;
    lsu_be   = 4'hF;
    mem_gnt  = 1'b1;
    @(negedge clk);
    checkVal("rstmid.lsu_gnt", lsu_gnt, 1'b1);
    @(posedge clk);
    #1;
    lsu_req = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    checkVal("rstmid.mem_req", mem_req, 1'b0);
    checkVal("rstmid.err_cleared", err, 1'b0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    @(negedge clk);
    checkVal("rstmid.late_lsu_rvalid", lsu_rvalid, 1'b0);
    checkVal("rstmid.late_ifu_rvalid", ifu_rvalid, 1'b0);
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    checkVal("rstmid.late_err", err, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
